elem_mem_write_sched: RTL
=========================

Name: elem_mem_write_sched

Overview:
- Burst write scheduler that lets N_REQ host-side requesters share the single element-memory write port (data/addr/proc_sel/mem_sel/en) feeding the per-core cmd/env/freq aligned_ram banks.
- Each requester hands over a burst descriptor, then streams data words. The block grants round-robin at burst boundaries and generates sequential write addresses.
- It sits between the host loaders (register bus, DMA) and the qdrv element memories alongside dsp.

Parameters:
N_REQ, 2, number of requesters
DATA_W, 32, write data width
ADDR_W, 16, write address width
LEN_W, 12, burst length field width (words)
N_PROC, 3, number of valid proc cores (proc_sel range 0..N_PROC-1)
N_MEM, 3, number of valid memory kinds (0 cmd, 1 env, 2 freq)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
hold  in  1  1 = do not start new bursts; an in-flight burst completes
req_valid  in  N_REQ  descriptor valid per requester
req_ready  out  N_REQ  descriptor accept, one-hot, single-cycle
req_proc  in  3*N_REQ  target proc core per requester
req_mem  in  3*N_REQ  target memory kind per requester
req_addr  in  ADDR_W*N_REQ  burst base address
req_len  in  LEN_W*N_REQ  burst length in words
dat_valid  in  N_REQ  data beat valid
dat_ready  out  N_REQ  data beat accept (only the granted requester)
dat_data  in  DATA_W*N_REQ  data words
mem_write_data  out  DATA_W  to memory write port
mem_write_addr  out  ADDR_W  to memory write port
proc_write_sel  out  3  to memory write port
mem_write_sel  out  3  to memory write port
mem_write_en  out  1  write strobe
busy  out  1  burst in progress (state != IDLE)
done  out  1  one-cycle pulse at burst end
done_id  out  $clog2(N_REQ)  requester that finished (valid with done)
err_sel  out  1  one-cycle pulse: out-of-range proc/mem select
err_len  out  1  one-cycle pulse: zero-length descriptor

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; rr pointer 0 (requester 0 has first priority); beat counter 0.
- States: IDLE, XFER, DONE.
- IDLE, hold=0, any req_valid:
  - Pick first valid requester at or after rr pointer, wrapping.
  - Assert req_ready[g] this cycle (combinational from registered state and req_valid).
  - Latch proc, mem, addr, len, g; set rr pointer to (g+1) mod N_REQ.
  - len==0: pulse err_len next cycle, stay IDLE, no done.
  - Otherwise go to XFER with cnt=0.
  - proc>=N_PROC or mem>=N_MEM: pulse err_sel next cycle and set a suppress flag for the burst.
- IDLE, hold=1: no req_ready. The descriptor waits; it is not dropped.
- XFER: dat_ready[g]=1, all others 0.
  - On dat_valid[g]&dat_ready[g], the next cycle drives mem_write_en=~suppress, mem_write_data=beat, mem_write_addr=(base+cnt) mod 2^ADDR_W, and the selects from the descriptor; then cnt++.
  - Latency is 1 cycle from handshake to write strobe. Throughput is 1 word/cycle.
  - The beat with cnt==len-1 moves to DONE. Address wraps silently past 2^ADDR_W-1.
- DONE: one cycle. done=1, done_id=g, dat_ready=0. Next state IDLE. New grants resume the cycle after DONE.
- mem_write_en is 0 in every cycle without an accepted beat in the preceding cycle. Outputs other than en hold their last value.
- hold during XFER has no effect. Descriptors from non-granted requesters stay pending.
- reset deasserted mid-burst: the burst is abandoned with no done; requesters re-issue.
- Width rule: cnt is LEN_W bits; max burst is 2^LEN_W-1 words.

Decomposition:
- Package elem_mem_sched_pkg holds:
  - the state enum
  - MEMSEL_CMD/ENV/FREQ constants (0/1/2)
  - the descriptor struct {proc, mem, addr, len}
  - localparam REQ_IDX_W = $clog2(N_REQ)
- Sub-module rr_arbiter (N parameter; request vector, enable, grant one-hot, grant index, pointer update on accept).

Test Plan:
1. Single burst: req0 proc=1 mem=2 addr=0x0010 len=4, data A,B,C,D back-to-back -> en for 4 consecutive cycles at addr 0x10..0x13, proc_write_sel=1, mem_write_sel=2; done pulse with done_id=0 one cycle after the last strobe.
2. Contention: req0 and req1 valid in the same cycle from reset, both len=2 -> req0 granted first, then req1; a second req0 while req1 runs waits until after req1's DONE.
3. Backpressure and wrap: addr=0xFFFE len=4, dat_valid toggled 1010… -> exactly 4 strobes at addr 0xFFFE, 0xFFFF, 0x0000, 0x0001, each one cycle after its handshake.
4. Errors: len=0 -> err_len pulse, no strobe, no done. proc=5 len=3 -> err_sel pulse, 3 beats consumed, en stays 0, done pulses.
5. hold: hold=1 with req0 valid for 10 cycles -> req_ready stays 0. Release -> grant the next cycle. hold raised mid-burst -> the burst completes.
6. Reset mid-burst: reset low after 2 of 5 beats -> all outputs 0 immediately, busy=0. After release, the new burst starts from rr pointer 0.

Source files
------------

// File: rtl/elem_mem_sched_pkg.sv
// elem_mem_sched_pkg: shared types and constants for the element-memory write scheduler
package elem_mem_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [2:0] MEMSEL_CMD  = 3'd0;
    localparam logic [2:0] MEMSEL_ENV  = 3'd1;
    localparam logic [2:0] MEMSEL_FREQ = 3'd2;

    localparam int SCHED_N_REQ = 2;
    localparam int REQ_IDX_W   = $clog2(SCHED_N_REQ);
    localparam int DESC_ADDR_W = 16;
    localparam int DESC_LEN_W  = 12;

    typedef struct packed {
        logic [2:0]             proc;
        logic [2:0]             mem;
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_LEN_W-1:0]  len;
    } desc_t;

    // a burst aimed at a core or memory kind that does not exist must not write
    function automatic logic sel_bad(input logic [2:0] proc, input logic [2:0] mem,
                                     input int n_proc, input int n_mem);
        return (int'(proc) >= n_proc) || (int'(mem) >= n_mem);
    endfunction

endpackage

// File: rtl/elem_mem_write_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant among N requesters with a pointer advanced on accept
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    input  logic          i_accept,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] r_ptr;

    // scan downward so the closest requester at or after the pointer wins
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (i_req[(int'(r_ptr) + k) % N]) o_idx = IW'((int'(r_ptr) + k) % N);
        o_gnt = (i_en && |i_req) ? N'(1) << o_idx : '0;
    end

    // pointer moves just past the accepted requester
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) r_ptr <= '0;
        else if (i_accept) r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;

endmodule

// File: rtl/elem_mem_write_sched.sv
// elem_mem_write_sched: round-robin burst scheduler onto the shared element-memory write port
module elem_mem_write_sched
    import elem_mem_sched_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = DESC_ADDR_W,
    parameter int LEN_W  = DESC_LEN_W,
    parameter int N_PROC = 3,
    parameter int N_MEM  = 3,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_hold,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [3*N_REQ-1:0]      i_req_proc,
    input  logic [3*N_REQ-1:0]      i_req_mem,
    input  logic [ADDR_W*N_REQ-1:0] i_req_addr,
    input  logic [LEN_W*N_REQ-1:0]  i_req_len,
    input  logic [N_REQ-1:0]        i_dat_valid,
    output logic [N_REQ-1:0]        o_dat_ready,
    input  logic [DATA_W*N_REQ-1:0] i_dat_data,
    output logic [DATA_W-1:0]       o_mem_write_data,
    output logic [ADDR_W-1:0]       o_mem_write_addr,
    output logic [2:0]              o_proc_write_sel,
    output logic [2:0]              o_mem_write_sel,
    output logic                    o_mem_write_en,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [IW-1:0]           o_done_id,
    output logic                    o_err_sel,
    output logic                    o_err_len
);

    state_t            r_state, w_next;
    desc_t             r_desc, w_desc;
    logic [IW-1:0]     r_gid, w_gidx;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_sup;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_grant_en, w_accept, w_beat, w_last, w_bad, w_zero;

    // grants only while idle, not held, and out of reset so nothing leaks during reset
    assign w_grant_en = i_reset && (r_state == S_IDLE) && !i_hold;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_req    (i_req_valid),
        .i_en     (w_grant_en),
        .i_accept (w_accept),
        .o_gnt    (w_gnt),
        .o_idx    (w_gidx)
    );

    assign w_accept = |w_gnt;
    assign w_desc   = '{proc: i_req_proc[3*int'(w_gidx) +: 3],
                        mem:  i_req_mem[3*int'(w_gidx) +: 3],
                        addr: i_req_addr[ADDR_W*int'(w_gidx) +: ADDR_W],
                        len:  i_req_len[LEN_W*int'(w_gidx) +: LEN_W]};
    assign w_bad    = sel_bad(w_desc.proc, w_desc.mem, N_PROC, N_MEM);
    assign w_zero   = (w_desc.len == '0);
    assign w_beat   = (r_state == S_XFER) && i_dat_valid[r_gid];
    assign w_last   = (r_cnt == r_desc.len - 1'b1);

    assign o_req_ready = w_gnt;
    assign o_dat_ready = (r_state == S_XFER) ? N_REQ'(1) << r_gid : '0;
    assign o_busy      = (r_state != S_IDLE);

    // state register
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) r_state <= S_IDLE;
        else r_state <= w_next;

    // next state: zero-length grants stay idle, the final beat closes the burst
    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? ((w_accept && !w_zero) ? S_XFER : S_IDLE) :
                 (r_state == S_XFER) ? ((w_beat && w_last) ? S_DONE : S_XFER) : S_IDLE;
    end

    // descriptor capture at grant and beat counting during the burst
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            r_desc <= '0;
            r_gid  <= '0;
            r_sup  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_desc <= w_desc;
            r_gid  <= w_gidx;
            r_sup  <= w_bad;
            r_cnt  <= '0;
        end else if (w_beat) begin
            r_cnt  <= r_cnt + 1'b1;
        end

    // write port: strobe follows each accepted beat by one cycle, other fields hold
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            o_mem_write_en   <= 1'b0;
            o_mem_write_data <= '0;
            o_mem_write_addr <= '0;
            o_proc_write_sel <= '0;
            o_mem_write_sel  <= '0;
        end else begin
            o_mem_write_en <= w_beat && !r_sup;
            if (w_beat) begin
                o_mem_write_data <= i_dat_data[DATA_W*int'(r_gid) +: DATA_W];
                o_mem_write_addr <= r_desc.addr + ADDR_W'(r_cnt);
                o_proc_write_sel <= r_desc.proc;
                o_mem_write_sel  <= r_desc.mem;
            end
        end

    // status pulses, each one cycle after the event that caused it
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            o_done    <= 1'b0;
            o_done_id <= '0;
            o_err_sel <= 1'b0;
            o_err_len <= 1'b0;
        end else begin
            o_done    <= (r_state == S_DONE);
            o_err_len <= w_accept && w_zero;
            o_err_sel <= w_accept && !w_zero && w_bad;
            if (r_state == S_DONE) o_done_id <= r_gid;
        end

endmodule
